// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg -- shared types and defaults for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, BURST)
//   N_DEF, DW_DEF, MAX_BURST_DEF : default requester count, data width, burst cap
//   idx_w()     : width of an index into N requesters (at least 1 bit)
package fifo_arb_pkg;

  localparam int N_DEF         = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- requester bundle plus FIFO write port of the arbiter.
//   req/req_valid/req_last/req_data : per-requester request, beat valid, last beat, data
//   ack/gnt                          : per-requester beat accept, registered ownership
//   full                             : FIFO full flag
//   wr_en/wr_data                    : FIFO write strobe and data
//   busy                             : arbiter is in a burst
// slave  : the arbiter side
// master : everything around it (requesters and FIFO)
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) ();

  logic [N-1:0]    req;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [N-1:0]    gnt;
  logic            full;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            busy;

  modport slave (
    input  req, req_valid, req_last, req_data, full,
    output ack, gnt, wr_en, wr_data, busy
  );

  modport master (
    output req, req_valid, req_last, req_data, full,
    input  ack, gnt, wr_en, wr_data, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin picker.
//   req        : request vector
//   last_owner : index of the previous owner; search starts just above it
//   onehot     : one-hot winner (zero when no request)
//   any        : at least one request present
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  onehot,
  output logic          any
);

  logic [N-1:0] w_hi_oh;
  logic [N-1:0] w_lo_oh;
  logic         w_hi_found;
  logic         w_lo_found;

  // Wrap-around search split in two: lowest request above last_owner wins,
  // otherwise the lowest request overall (the wrapped part).
  always_comb begin
    w_hi_oh    = '0;
    w_lo_oh    = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (IW'(i) > last_owner) && !w_hi_found) begin
        w_hi_oh[i] = 1'b1;
        w_hi_found = 1'b1;
      end
      if (req[i] && !w_lo_found) begin
        w_lo_oh[i] = 1'b1;
        w_lo_found = 1'b1;
      end
    end
  end

  assign onehot = w_hi_found ? w_hi_oh : w_lo_oh;
  assign any    = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- N requesters share one FIFO write port, round-robin,
// one burst per grant, capped at MAX_BURST beats.
//   wr_clk : clock
//   wr_rst : synchronous active-high reset
//   bus    : fifo_wr_arbiter_if.slave (requests in, acks/grant/FIFO write out)
//
// state | meaning
// IDLE  | no owner; arbitrate among req, register the winner into gnt
// BURST | gnt owner transfers beats until last, MAX_BURST beats, or req drop
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic             wr_clk,
  input logic             wr_rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int             IW        = idx_w(N);
  localparam int             CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0]  OWNER_RST = IW'(N - 1);

  arb_state_t    r_state;
  logic [N-1:0]  r_gnt;
  logic [CW-1:0] r_beat_cnt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last_owner;

  arb_state_t    w_state_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] w_last_owner_nxt;

  logic [N-1:0]  w_pick_oh;
  logic          w_pick_any;
  logic [IW-1:0] w_pick_idx;
  logic          w_beat;
  logic          w_owner_req;
  logic          w_owner_last;
  logic          w_release;
  logic [DW-1:0] w_wr_data;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (bus.req),
    .last_owner (r_last_owner),
    .onehot     (w_pick_oh),
    .any        (w_pick_any)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_oh[i]) w_pick_idx = IW'(i);
    end
  end

  assign w_beat       = (|(r_gnt & bus.req_valid)) && !bus.full;
  assign w_owner_req  = |(r_gnt & bus.req);
  assign w_owner_last = |(r_gnt & bus.req_valid & bus.req_last);
  // Last beat and burst cap landing on the same beat collapse into one release.
  assign w_release    = (w_beat && (w_owner_last || (r_beat_cnt == CNT_LAST)))
                        || !w_owner_req;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_beat_cnt   <= '0;
      r_owner      <= '0;
      r_last_owner <= OWNER_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_beat_cnt   <= w_cnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_cnt_nxt        = r_beat_cnt;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = BURST;
          w_gnt_nxt   = w_pick_oh;
          w_cnt_nxt   = '0;
          w_owner_nxt = w_pick_idx;
        end
      end
      BURST: begin
        // A full FIFO freezes the burst entirely, including a req drop.
        if (!bus.full) begin
          if (w_beat) w_cnt_nxt = r_beat_cnt + 1'b1;
          if (w_release) begin
            w_state_nxt      = IDLE;
            w_gnt_nxt        = '0;
            w_cnt_nxt        = '0;
            w_last_owner_nxt = r_owner;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while wr_rst is high so a reset landing mid-burst
  // cannot push one more beat into the FIFO.
  always_comb begin
    w_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt[i]) w_wr_data = bus.req_data[i*DW +: DW];
    end
    bus.wr_en   = w_beat && !wr_rst;
    bus.ack     = {N{w_beat && !wr_rst}} & r_gnt;
    bus.busy    = (r_state == BURST) && !wr_rst;
    bus.wr_data = wr_rst ? '0 : w_wr_data;
    bus.gnt     = r_gnt;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic wr_clk = 1'b0;
  logic wr_rst;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] gnt;
    logic       wr_en;
    logic       busy;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] sb_exp;
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] valid,
                              input logic [3:0] last, input logic full,
                              input logic [3:0] gnt, input logic wr_en,
                              input logic busy);
    vec_t v;
    v.req = req; v.valid = valid; v.last = last; v.full = full;
    v.gnt = gnt; v.wr_en = wr_en; v.busy = busy;
    return v;
  endfunction

  function automatic logic [DW-1:0] data_for(input int i, input int k);
    return DW'(((i + 1) << 4) | (k & 15));
  endfunction

  function automatic int owner_of(input logic [3:0] g);
    int o;
    o = 0;
    for (int i = 0; i < N; i++) if (g[i]) o = i;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle just after the edge, then check mid-cycle.
  task automatic run_cycle(input vec_t v, input int k, input logic rst, input string tag);
    logic [DW-1:0] exp_data;
    @(posedge wr_clk);
    #1;
    wr_rst        = rst;
    bus.req       = v.req;
    bus.req_valid = v.valid;
    bus.req_last  = v.last;
    bus.full      = v.full;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_for(i, k);
    if (v.wr_en) sb_q.push_back(data_for(owner_of(v.gnt), k));
    exp_data = (rst || v.gnt == 4'b0) ? '0 : data_for(owner_of(v.gnt), k);
    @(negedge wr_clk);
    chk($sformatf("%s[%0d] gnt", tag, k),     32'(bus.gnt),     32'(v.gnt));
    chk($sformatf("%s[%0d] wr_en", tag, k),   32'(bus.wr_en),   32'(v.wr_en));
    chk($sformatf("%s[%0d] ack", tag, k),     32'(bus.ack),     32'(v.wr_en ? v.gnt : 4'b0));
    chk($sformatf("%s[%0d] busy", tag, k),    32'(bus.busy),    32'(v.busy));
    chk($sformatf("%s[%0d] wr_data", tag, k), 32'(bus.wr_data), 32'(exp_data));
  endtask

  // Scoreboard: every FIFO write must match the next expected beat.
  always @(negedge wr_clk) begin
    if (bus.wr_en === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: write of %0h with no beat expected", bus.wr_data);
      end else begin
        sb_exp = sb_q.pop_front();
        if (bus.wr_data !== sb_exp) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", bus.wr_data, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_rst        = 1'b1;
    bus.req       = 4'b1111;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0;
    bus.full      = 1'b0;
    bus.req_data  = '0;

    // Round robin from reset, 1-beat packets: 0,1,2,3,0 with IDLE gaps.
    for (int r = 0; r < 5; r++) begin
      vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0));
      vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'(1 << (r % 4)), 1'b1, 1'b1));
    end
    // 3-beat packet from requester 0; valid already high in IDLE moves nothing.
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    // Owner 2 streams 12 beats, capped at 8; req[3] waits, then gets a turn.
    vecs.push_back(mk(4'b1100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    for (int b = 0; b < 8; b++)
      vecs.push_back(mk(4'b1100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1));
    vecs.push_back(mk(4'b1100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1100, 4'b1100, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    for (int b = 0; b < 3; b++)
      vecs.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    // Full for 5 cycles after beat 2 (last during full is not a beat),
    // one valid-low cycle, 6 beats total over 12 owned cycles.
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1));
    for (int f = 0; f < 5; f++)
      vecs.push_back(mk(4'b0001, 4'b0001, (f == 2) ? 4'b0001 : 4'b0000, 1'b1,
                        4'b0001, 1'b0, 1'b1));
    for (int b = 0; b < 3; b++)
      vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    // Last on the 8th beat: one release, one IDLE cycle, then re-grant.
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    for (int b = 0; b < 7; b++)
      vecs.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    // Owner 1 drops req after 2 beats; next pick searches from 2.
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0110, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0110, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));

    // Reset held with requests and valids up: everything quiet.
    for (int c = 0; c < 3; c++)
      run_cycle(mk(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0), 200 + c, 1'b1, "rst");

    foreach (vecs[k]) run_cycle(vecs[k], k, 1'b0, "vec");

    // Reset on beat 2 of owner 1's burst: no beat 2, then requester 0 first.
    run_cycle(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0), 100, 1'b0, "mid_rst");
    run_cycle(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1), 101, 1'b0, "mid_rst");
    run_cycle(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0), 102, 1'b1, "mid_rst");
    run_cycle(mk(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0), 103, 1'b0, "mid_rst");
    run_cycle(mk(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1), 104, 1'b0, "mid_rst");
    run_cycle(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0), 105, 1'b0, "mid_rst");

    @(posedge wr_clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N, default 4: number of write requesters sharing one FIFO write port.
REQ-002 Parameter DW, default 8: data width per requester.
REQ-003 Parameter MAX_BURST, default 8: maximum beats per grant, range 1..255.
REQ-004 wr_clk  input  1  single clock for the whole block.
REQ-005 wr_rst  input  1  synchronous reset, active-high, sampled on posedge wr_clk.
REQ-006 req  input  N  per-requester bus request, level-held while the requester has a packet.
REQ-007 req_valid  input  N  per-requester data beat valid.
REQ-008 req_last  input  N  per-requester final beat of packet; qualified by req_valid.
REQ-009 req_data  input  N*DW  requester data, requester i occupies bits [i*DW +: DW].
REQ-010 ack  output  N  per-requester beat accepted this cycle.
REQ-011 gnt  output  N  registered one-hot ownership, all-zero when no owner.
REQ-012 full  input  1  FIFO full flag from the write-pointer logic.
REQ-013 wr_en  output  1  FIFO write enable.
REQ-014 wr_data  output  DW  FIFO write data.
REQ-015 busy  output  1  high whenever state is BURST.

Function
REQ-016 The block SHALL implement two states: IDLE and BURST.
REQ-017 IDLE, with no bit of req set: stay in IDLE, gnt = 0.
REQ-018 IDLE, with any bit of req set: pick a winner round-robin, searching from (last_owner+1) mod N upward with wrap. Register gnt = onehot(winner), clear beat_cnt, and go to BURST on the next edge.
REQ-019 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt high; no transfer occurs in the IDLE cycle.
REQ-020 A beat SHALL be defined as gnt[i] & req_valid[i] & !full, evaluated combinationally in the same cycle.
REQ-021 wr_en SHALL equal OR over i of (gnt[i] & req_valid[i]) & !full; wr_en SHALL never be high while full is high.
REQ-022 wr_data SHALL equal the owner's req_data slice when gnt is nonzero, and 0 otherwise.
REQ-023 ack[i] SHALL equal wr_en & gnt[i].
REQ-024 Each beat SHALL increment beat_cnt, which is ceil(log2(MAX_BURST+1)) bits wide and never wraps.
REQ-025 BURST SHALL release to IDLE on the edge after any one of these: a beat with req_last; a beat that makes beat_cnt equal MAX_BURST; req[owner] sampled low.
REQ-026 On release, last_owner SHALL be set to the owner, gnt cleared, and beat_cnt cleared.
REQ-027 While full is high in BURST, the block SHALL hold state, gnt, and beat_cnt unchanged.
REQ-028 req_valid low in BURST SHALL hold ownership without a beat.
REQ-029 req_last and beat_cnt reaching MAX_BURST in the same beat SHALL cause a single release.
REQ-030 Requests on non-owner lines during BURST SHALL be ignored until IDLE; no preemption.
REQ-031 After release, the earliest re-grant SHALL be 2 cycles later, because of the mandatory IDLE arbitration cycle.

Reset
REQ-032 On wr_rst the block SHALL set state=IDLE, gnt=0, beat_cnt=0, and last_owner=N-1, so requester 0 has first priority.
REQ-033 During reset, wr_en, ack, and busy SHALL be 0 and wr_data SHALL be 0.
REQ-034 Reset asserted mid-BURST SHALL abort the burst with no further beats; any partial packet already written remains in the FIFO.

Structure
REQ-035 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default values of N, DW, and MAX_BURST.
REQ-036 Sub-module rr_pick SHALL be a combinational round-robin picker: inputs req[N] and last_owner; outputs onehot[N] and any.
REQ-037 All state SHALL be in the wr_clk domain; the block adds no synchronizers.

Verification
REQ-038 Reset release, then req=4'b0001 with a 3-beat packet (last on beat 3), full=0 -> gnt=0001 at cycle 1, wr_en high for cycles 1-3, IDLE at cycle 4.
REQ-039 req=4'b1111 held, 1-beat packets -> grant order 0,1,2,3,0, with one IDLE cycle between each grant.
REQ-040 Owner 2 streams 12 beats without last, MAX_BURST=8 -> release after 8 beats; gnt next moves to 3 if req[3] is set, otherwise back to 2.
REQ-041 full=1 for 5 cycles mid-burst, owner valid -> wr_en=0 and ack=0 for those cycles, beat_cnt frozen, burst resumes and completes.
REQ-042 Owner drops req after 2 beats with no last -> IDLE the next cycle, last_owner updated.
REQ-043 wr_rst asserted on beat 2 of a burst -> next cycle gnt=0, wr_en=0, state IDLE; after reset release, requester 0 has priority.
